// File: rtl/nios_accelerometer_switch_ctrl.sv
// nios_accelerometer_switch_ctrl: Avalon-MM switch input with sync, debounce,
// sticky edge capture and a maskable level interrupt for the Nios.
module nios_accelerometer_switch_ctrl #(
  parameter int WIDTH = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1, r_sync2, r_sample, r_deb, r_deb_d, r_mask, r_cap;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_cfg;
  logic             r_sampled, r_valid, r_irq;
  logic [31:0]      r_rdata;

  logic             w_wr, w_tick, w_deb_upd;
  logic [WIDTH-1:0] w_agree, w_deb_nxt, w_edge, w_w1c, w_mask_nxt, w_cap_nxt;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_unused = ^writedata;
  assign readdata = r_rdata;
  assign irq      = r_irq;

  always_comb begin
    w_wr       = chipselect & ~write_n;
    w_tick     = r_cnt == LAST;
    w_agree    = ~(r_sync2 ^ r_sample);
    // Debounced register only updates once a previous sample exists to agree with.
    w_deb_upd  = r_cfg[0] ? (w_tick & r_sampled) : 1'b1;
    w_deb_nxt  = !w_deb_upd ? r_deb :
                 r_cfg[0] ? ((r_deb & ~w_agree) | (r_sync2 & w_agree)) : r_sync2;
    w_edge     = !r_valid ? '0 :
                 ((r_cfg[1] ? (r_deb & ~r_deb_d) : '0) |
                  (r_cfg[2] ? (~r_deb & r_deb_d) : '0));
    w_w1c      = (w_wr && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    w_mask_nxt = (w_wr && address == 2'd1) ? writedata[WIDTH-1:0] : r_mask;
    w_cap_nxt  = (r_cap & ~w_w1c) | w_edge;
    w_rd       = address == 2'd0 ? 32'(r_deb) :
                 address == 2'd1 ? 32'(r_mask) :
                 address == 2'd2 ? 32'(r_cap) : 32'(r_cfg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sample  <= '0;
      r_deb     <= '0;
      r_deb_d   <= '0;
      r_mask    <= '0;
      r_cap     <= '0;
      r_cnt     <= '0;
      r_cfg     <= 3'b111;
      r_sampled <= 1'b0;
      r_valid   <= 1'b0;
      r_irq     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_sync1   <= in_port;
      r_sync2   <= r_sync1;
      r_cnt     <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick && r_cfg[0]) begin
        r_sample  <= r_sync2;
        r_sampled <= 1'b1;
      end
      r_deb     <= w_deb_nxt;
      // Until primed, deb_d follows the next debounced value so levels present at reset never look like edges.
      r_deb_d   <= r_valid ? r_deb : w_deb_nxt;
      r_valid   <= r_valid | w_deb_upd;
      r_mask    <= w_mask_nxt;
      r_cap     <= w_cap_nxt;
      r_irq     <= |(w_cap_nxt & w_mask_nxt);
      if (w_wr && address == 2'd3) r_cfg <= writedata[2:0];
      r_rdata   <= w_rd;
    end
  end
endmodule

// File: tb/tb_nios_accelerometer_switch_ctrl.sv
// tb_nios_accelerometer_switch_ctrl: directed vectors plus hand sequences for
// debounce latency, bounce rejection, W1C/set collision and async reset.
module tb_nios_accelerometer_switch_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  in_port = 10'h3FF;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  nios_accelerometer_switch_ctrl #(.WIDTH(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  inp;
    logic        we;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t tbl[16];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    tick(1);
    chk(name, readdata, exp);
  endtask

  initial begin
    int cyc;
    int changes;
    logic prev;
    logic [31:0] trace [1:7];
    tbl[0]  = '{10'h3FB, 1'b1, 2'd1, 32'h0000_0020, 2'd1, 32'h20,  1'b0};
    tbl[1]  = '{10'h3FB, 1'b0, 2'd0, 32'h0,         2'd3, 32'h6,   1'b0};
    tbl[2]  = '{10'h3DB, 1'b0, 2'd0, 32'h0,         2'd2, 32'h20,  1'b1};
    tbl[3]  = '{10'h3DB, 1'b0, 2'd0, 32'h0,         2'd0, 32'h3DB, 1'b1};
    tbl[4]  = '{10'h3DB, 1'b1, 2'd1, 32'h0,         2'd1, 32'h0,   1'b0};
    tbl[5]  = '{10'h3DB, 1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h3DB, 1'b0};
    tbl[6]  = '{10'h3DB, 1'b1, 2'd3, 32'hFFFF_FFFC, 2'd3, 32'h4,   1'b0};
    tbl[7]  = '{10'h3FB, 1'b1, 2'd2, 32'h0000_0020, 2'd2, 32'h0,   1'b0};
    tbl[8]  = '{10'h3DB, 1'b0, 2'd0, 32'h0,         2'd2, 32'h20,  1'b0};
    tbl[9]  = '{10'h3DB, 1'b1, 2'd1, 32'h0000_03FF, 2'd1, 32'h3FF, 1'b1};
    tbl[10] = '{10'h3DB, 1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0,   1'b0};
    tbl[11] = '{10'h3DB, 1'b1, 2'd3, 32'h0,         2'd3, 32'h0,   1'b0};
    tbl[12] = '{10'h000, 1'b0, 2'd0, 32'h0,         2'd2, 32'h0,   1'b0};
    tbl[13] = '{10'h000, 1'b0, 2'd0, 32'h0,         2'd0, 32'h0,   1'b0};
    tbl[14] = '{10'h000, 1'b1, 2'd3, 32'h6,         2'd2, 32'h0,   1'b0};
    tbl[15] = '{10'h000, 1'b0, 2'd0, 32'h0,         2'd3, 32'h6,   1'b0};

    // Reset with all switches on: no edges once primed
    tick(3);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    tick(12);
    rd_chk("init_data", 2'd0, 32'h3FF);
    rd_chk("init_cap", 2'd2, 32'h0);
    rd_chk("init_cfg", 2'd3, 32'h7);
    rd_chk("init_mask", 2'd1, 32'h0);
    chk("init_irq", 32'(irq), 32'h0);

    // bit0 fall captured with default both-edge select, then rise latency with rising-only select
    in_port = 10'h3FE;
    tick(14);
    rd_chk("fall0_cap", 2'd2, 32'h1);
    wr(2'd2, 32'h1);
    wr(2'd1, 32'h1);
    wr(2'd3, 32'h3);
    in_port = 10'h3FF;
    cyc = 0;
    for (int i = 1; i <= 14 && cyc == 0; i++) begin
      tick(1);
      if (irq) cyc = i;
    end
    n_vec++;
    if (cyc < 8 || cyc > 11) begin
      n_err++;
      $display("FAIL irq_latency: got %0d cycles (0 = timeout), expected 8..11", cyc);
    end
    rd_chk("rise0_data", 2'd0, 32'h3FF);
    rd_chk("rise0_cap", 2'd2, 32'h1);
    chk("rise0_irq", 32'(irq), 32'h1);
    wr(2'd2, 32'h1);
    chk("w1c_irq", 32'(irq), 32'h0);
    rd_chk("w1c_cap", 2'd2, 32'h0);

    // Bounce on bit3 must yield a single debounced change and a single capture
    in_port = 10'h3F7;
    tick(14);
    rd_chk("fall3_ignored", 2'd2, 32'h0);
    address = 2'd0;
    tick(1);
    prev = readdata[3];
    changes = 0;
    for (int i = 0; i < 13; i++) begin
      if (i < 7) in_port[3] = (i % 2 == 0);
      else in_port[3] = 1'b1;
      repeat (3) begin
        tick(1);
        if (readdata[3] != prev) changes++;
        prev = readdata[3];
      end
    end
    chk("bounce_changes", 32'(changes), 32'h1);
    chk("bounce_final", 32'(prev), 32'h1);
    rd_chk("bounce_cap", 2'd2, 32'h8);
    chk("bounce_irq", 32'(irq), 32'h0);

    // Bypass mode; W1C on bit2 in the same cycle a new bit2 edge is captured
    wr(2'd3, 32'h6);
    wr(2'd2, 32'hFFFF_FFFF);
    tick(4);
    rd_chk("coll_pre", 2'd2, 32'h0);
    in_port = 10'h3FB;
    tick(3);
    wr(2'd2, 32'h4);
    rd_chk("coll_set_wins", 2'd2, 32'h4);
    wr(2'd2, 32'h4);
    rd_chk("coll_cleared", 2'd2, 32'h0);

    for (int i = 0; i < 16; i++) begin
      in_port = tbl[i].inp;
      if (tbl[i].we) wr(tbl[i].wa, tbl[i].wd);
      else tick(1);
      tick(3);
      rd_chk($sformatf("vec%0d_rd", i), tbl[i].ra, tbl[i].rd);
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
    end

    // Two-cycle pulse on bit9 in bypass: follows 3 cycles later, both edges captured
    address = 2'd0;
    in_port = 10'h200;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      if (k == 2) in_port = 10'h000;
      trace[k] = readdata;
    end
    chk("pulse_k3", trace[3], 32'h0);
    chk("pulse_k4", trace[4], 32'h200);
    chk("pulse_k5", trace[5], 32'h200);
    chk("pulse_k6", trace[6], 32'h0);
    rd_chk("pulse_cap", 2'd2, 32'h200);
    chk("pulse_irq", 32'(irq), 32'h1);

    // Asynchronous reset mid-test clears outputs without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", readdata, 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    tick(2);
    reset_n = 1'b1;
    rd_chk("post_rst_cfg", 2'd3, 32'h7);
    rd_chk("post_rst_cap", 2'd2, 32'h0);
    rd_chk("post_rst_mask", 2'd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
